// File: rtl/sdrd_seq_pkg.sv
// Shared widths, field positions, state encoding and ICB command payload
// for the sdrd multi-sector read sequencer.
package sdrd_seq_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MASK_W       = 4;
  localparam int unsigned SEC_W        = 32;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned BIDX_W       = 9;
  localparam int unsigned POLL_W       = 24;
  localparam int unsigned SETTLE_W     = 16;
  localparam int unsigned ERR_W        = 2;

  // sdrd read data fields
  localparam int unsigned RSP_BUSY_BIT = 24;
  localparam int unsigned RSP_BYTE_LSB = 0;

  localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
  localparam logic [ERR_W-1:0] ERR_RSP  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TMO  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WSEC   = 4'd1,
    S_SETTLE = 4'd2,
    S_PCMD   = 4'd3,
    S_PRSP   = 4'd4,
    S_RCMD   = 4'd5,
    S_RRSP   = 4'd6,
    S_PUSH   = 4'd7,
    S_NSEC   = 4'd8,
    S_DONE   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } icb_cmd_t;

  // Buffer byte carried in an sdrd read response
  function automatic logic [7:0] rsp_byte(input logic [DATA_W-1:0] rdata);
    return rdata[RSP_BYTE_LSB +: 8];
  endfunction

endpackage

// File: rtl/sdrd_byte_pack.sv
// Little-endian 4-byte pack register: writes byte_in into lane, clr zeroes the word.
// Ports: clk, rst_n, clr, wr_en, lane[1:0], byte_in[7:0] -> word[31:0]
module sdrd_byte_pack
  import sdrd_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [1:0]        lane,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (wr_en) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
    end
  end

endmodule

// File: rtl/sdrd_seq.sv
// Multi-sector read sequencer: ICB master on sdrd that writes the sector number,
// polls busy, reads the 512 buffer bytes and streams them as packed 32-bit words.
// Ports: start/start_sector/sector_cnt/dst_base config; busy/done/err status;
//        m_cmd_*/m_rsp_* ICB master; wr_valid/wr_ready/wr_addr/wr_data word stream.
module sdrd_seq
  import sdrd_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SDRD_BASE  = 32'h0000_0000,
  parameter int unsigned       SETTLE_CYC = 16,
  parameter logic [POLL_W-1:0] POLL_MAX   = 24'hFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEC_W-1:0]  start_sector,
  input  logic [CNT_W-1:0]  sector_cnt,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic              m_cmd_read,
  output logic [DATA_W-1:0] m_cmd_wdata,
  output logic [MASK_W-1:0] m_cmd_wmask,
  input  logic              m_rsp_valid,
  output logic              m_rsp_ready,
  input  logic              m_rsp_err,
  input  logic [DATA_W-1:0] m_rsp_rdata,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  state_t              state_q, state_d;
  logic [SEC_W-1:0]    sec_cur_q, sec_cur_d;
  logic [CNT_W-1:0]    sec_idx_q, sec_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0]    err_d;
  logic                done_d;
  logic                cmd_valid_d;
  icb_cmd_t            cmd_q, cmd_d;
  logic                wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic                pack_clr_c;
  logic                pack_wr_c;
  logic [DATA_W-1:0]   pack_word;
  logic                unused_c;

  // Response bits other than busy/byte and the word-aligning address bits are don't-care
  assign unused_c = ^{m_rsp_rdata[31:25], m_rsp_rdata[23:8], dst_base[1:0]};

  assign m_rsp_ready = 1'b1;
  assign m_cmd_addr  = cmd_q.addr;
  assign m_cmd_read  = cmd_q.read;
  assign m_cmd_wdata = cmd_q.wdata;
  assign m_cmd_wmask = cmd_q.wmask;
  assign wr_data     = pack_word;

  sdrd_byte_pack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pack_clr_c),
    .wr_en   (pack_wr_c),
    .lane    (byte_idx_q[1:0]),
    .byte_in (rsp_byte(m_rsp_rdata)),
    .word    (pack_word)
  );

  // Next state, datapath updates, and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    sec_cur_d   = sec_cur_q;
    sec_idx_d   = sec_idx_q;
    cnt_d       = cnt_q;
    dst_d       = dst_q;
    byte_idx_d  = byte_idx_q;
    poll_cnt_d  = poll_cnt_q;
    settle_d    = settle_q;
    err_d       = err;
    done_d      = 1'b0;
    pack_clr_c  = 1'b0;
    pack_wr_c   = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_d       = '0;
    wr_valid_d  = 1'b0;
    wr_addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = ERR_NONE;
          if (sector_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            sec_cur_d  = start_sector;
            sec_idx_d  = '0;
            cnt_d      = sector_cnt;
            dst_d      = {dst_base[ADDR_W-1:2], 2'b00};
            poll_cnt_d = '0;
            state_d    = S_WSEC;
          end
        end
      end
      S_WSEC: begin
        if (m_cmd_ready) begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // The sector-write response lands in this window
        if (m_rsp_valid && m_rsp_err) begin
          err_d   = ERR_RSP;
          done_d  = 1'b1;
          state_d = S_ERR;
        end else if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
          state_d = S_PCMD;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      S_PCMD: begin
        if (m_cmd_ready) state_d = S_PRSP;
      end
      S_PRSP: begin
        if (m_rsp_valid) begin
          if (m_rsp_err) begin
            err_d   = ERR_RSP;
            done_d  = 1'b1;
            state_d = S_ERR;
          end else if (m_rsp_rdata[RSP_BUSY_BIT]) begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            if (poll_cnt_d == POLL_MAX) begin
              err_d   = ERR_TMO;
              done_d  = 1'b1;
              state_d = S_ERR;
            end else begin
              state_d = S_PCMD;
            end
          end else begin
            byte_idx_d = '0;
            pack_clr_c = 1'b1;
            state_d    = S_RCMD;
          end
        end
      end
      S_RCMD: begin
        if (m_cmd_ready) state_d = S_RRSP;
      end
      S_RRSP: begin
        if (m_rsp_valid) begin
          if (m_rsp_err) begin
            err_d   = ERR_RSP;
            done_d  = 1'b1;
            state_d = S_ERR;
          end else begin
            pack_wr_c = 1'b1;
            if (byte_idx_q[1:0] == 2'd3) begin
              state_d = S_PUSH;
            end else begin
              byte_idx_d = byte_idx_q + BIDX_W'(1);
              state_d    = S_RCMD;
            end
          end
        end
      end
      S_PUSH: begin
        if (wr_ready) begin
          if (byte_idx_q == '1) begin
            state_d = S_NSEC;
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
            state_d    = S_RCMD;
          end
        end
      end
      S_NSEC: begin
        sec_idx_d = sec_idx_q + CNT_W'(1);
        sec_cur_d = sec_cur_q + SEC_W'(1);
        if (sec_idx_d == cnt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          poll_cnt_d = '0;
          state_d    = S_WSEC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ICB command and word-stream outputs are registered from the next state
    cmd_valid_d = (state_d == S_WSEC) || (state_d == S_PCMD) || (state_d == S_RCMD);
    case (state_d)
      S_WSEC: begin
        cmd_d.addr  = SDRD_BASE;
        cmd_d.wdata = sec_cur_d;
        cmd_d.wmask = 4'hF;
      end
      S_PCMD: begin
        cmd_d.addr = SDRD_BASE;
        cmd_d.read = 1'b1;
      end
      S_RCMD: begin
        cmd_d.addr = SDRD_BASE + ADDR_W'({byte_idx_d, 2'b00});
        cmd_d.read = 1'b1;
      end
      default: ;
    endcase

    wr_valid_d = (state_d == S_PUSH);
    if (wr_valid_d) begin
      wr_addr_d = dst_q + (ADDR_W'(sec_idx_d) << 9) + ADDR_W'({byte_idx_d[8:2], 2'b00});
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sec_cur_q   <= '0;
      sec_idx_q   <= '0;
      cnt_q       <= '0;
      dst_q       <= '0;
      byte_idx_q  <= '0;
      poll_cnt_q  <= '0;
      settle_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_NONE;
      m_cmd_valid <= 1'b0;
      cmd_q       <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
    end else begin
      state_q     <= state_d;
      sec_cur_q   <= sec_cur_d;
      sec_idx_q   <= sec_idx_d;
      cnt_q       <= cnt_d;
      dst_q       <= dst_d;
      byte_idx_q  <= byte_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      settle_q    <= settle_d;
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
      err         <= err_d;
      m_cmd_valid <= cmd_valid_d;
      cmd_q       <= cmd_d;
      wr_valid    <= wr_valid_d;
      wr_addr     <= wr_addr_d;
    end
  end

endmodule
